// File: rtl/fm_hop_sequencer.sv
// Hop-table frequency sequencer: a wishbone-programmed table of frequency words
// stepped out to the FM generator, one word per hop, with a programmable dwell.
module fm_hop_sequencer #(
    parameter int unsigned accumulator_width = 32,
    parameter int unsigned dwell_width       = 24,
    parameter int unsigned table_log2        = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    input  logic                         i_wb_we,
    input  logic [4:0]                   i_wb_addr,
    input  logic [31:0]                  i_wb_data,
    output logic                         o_wb_ack,
    output logic                         o_wb_stall,
    output logic [31:0]                  o_wb_data,
    output logic [accumulator_width-1:0] o_freq_word,
    output logic                         o_freq_stb,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int unsigned table_depth = 1 << table_log2;
    localparam int unsigned len_width   = table_log2 + 1;

    localparam logic [4:0] addr_ctrl   = 5'd0;
    localparam logic [4:0] addr_dwell  = 5'd1;
    localparam logic [4:0] addr_length = 5'd2;
    localparam logic [4:0] addr_status = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL
    } state_t;

    state_t                         state_q, state_d;
    logic [table_log2-1:0]          idx_q, idx_d;
    logic [dwell_width-1:0]         cnt_q, cnt_d;
    logic                           fin_q, fin_d;
    logic                           start_pend_q;

    logic [dwell_width-1:0]         dwell_q;
    logic [len_width-1:0]           length_q;
    logic [len_width-1:0]           len_q;
    logic                           loop_q;
    logic                           sticky_q;
    logic                           status_rd_q;
    logic [accumulator_width-1:0]   table_q [table_depth];

    logic                           wr_c;
    logic                           rd_c;
    logic                           ctrl_wr_c;
    logic                           start_c;
    logic                           stop_c;
    logic [len_width-1:0]           length_wr_c;
    logic [31:0]                    rd_data_c;

    assign o_wb_stall = 1'b0;

    assign wr_c        = i_wb_cyc & i_wb_stb & i_wb_we;
    assign rd_c        = i_wb_cyc & i_wb_stb & ~i_wb_we;
    assign ctrl_wr_c   = wr_c && (i_wb_addr == addr_ctrl);
    // A start is only accepted from a quiet IDLE; otherwise a RUN=1 write just updates LOOP.
    assign start_c     = ctrl_wr_c && i_wb_data[0] && (state_q == ST_IDLE) &&
                         !start_pend_q && (length_q != '0);
    assign stop_c      = ctrl_wr_c && !i_wb_data[0];
    assign length_wr_c = (i_wb_data > 32'(table_depth)) ? len_width'(table_depth)
                                                         : i_wb_data[len_width-1:0];

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            fin_q        <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            fin_q        <= fin_d;
            start_pend_q <= start_c;
        end
    end

    // Next-state logic; the start write is held one cycle before LOAD
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fin_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pend_q && !stop_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_DWELL;
                cnt_d   = (dwell_q == '0) ? '0 : dwell_q - dwell_width'(1);
            end
            ST_DWELL: begin
                if (cnt_q == '0) begin
                    if (len_width'(idx_q) + len_width'(1) < len_q) begin
                        idx_d   = idx_q + table_log2'(1);
                        state_d = ST_LOAD;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        fin_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - dwell_width'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A stop aborts silently; any strobe of the current LOAD still goes out
        if (stop_c && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            fin_d   = 1'b0;
        end
        if (start_c) idx_d = '0;
    end

    // Register read mux
    always_comb begin
        rd_data_c = '0;
        if (i_wb_addr[4]) begin
            rd_data_c = 32'(table_q[i_wb_addr[table_log2-1:0]]);
        end else begin
            case (i_wb_addr)
                addr_ctrl:   rd_data_c = {30'd0, loop_q, o_busy};
                addr_dwell:  rd_data_c = 32'(dwell_q);
                addr_length: rd_data_c = 32'(length_q);
                addr_status: rd_data_c = 32'({sticky_q, idx_q, 3'b000, o_busy});
                default:     rd_data_c = '0;
            endcase
        end
    end

    // Registers, table and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack    <= 1'b0;
            o_wb_data   <= '0;
            o_freq_word <= '0;
            o_freq_stb  <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            dwell_q     <= '0;
            length_q    <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            sticky_q    <= 1'b0;
            status_rd_q <= 1'b0;
            for (int unsigned i = 0; i < table_depth; i++) table_q[i] <= '0;
        end else begin
            o_wb_ack    <= i_wb_cyc & i_wb_stb;
            o_wb_data   <= rd_c ? rd_data_c : '0;
            o_freq_stb  <= (state_q == ST_LOAD);
            if (state_q == ST_LOAD) o_freq_word <= table_q[idx_q];
            o_busy      <= (state_d != ST_IDLE);
            o_done      <= fin_q;
            status_rd_q <= rd_c && (i_wb_addr == addr_status);
            if (fin_q)            sticky_q <= 1'b1;
            else if (status_rd_q) sticky_q <= 1'b0;
            if (ctrl_wr_c) loop_q <= i_wb_data[1];
            if (start_c)   len_q  <= length_q;
            if (wr_c && (i_wb_addr == addr_dwell))  dwell_q  <= i_wb_data[dwell_width-1:0];
            if (wr_c && (i_wb_addr == addr_length)) length_q <= length_wr_c;
            if (wr_c && i_wb_addr[4])
                table_q[i_wb_addr[table_log2-1:0]] <= i_wb_data[accumulator_width-1:0];
        end
    end

endmodule
